// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ID/EX ALU control stage: ALU codes, main-decoder
// opcodes, R-type function codes, mult/div op encodings and sequencer states.
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1000;
  localparam logic [3:0] ALU_XOR  = 4'b1001;
  localparam logic [3:0] ALU_SLTU = 4'b1010;
  localparam logic [3:0] ALU_LUI  = 4'b1011;
  localparam logic [3:0] ALU_NOP  = 4'b1111;

  localparam logic [2:0] AOP_RTYPE = 3'b000;
  localparam logic [2:0] AOP_ADD   = 3'b001;
  localparam logic [2:0] AOP_SUB   = 3'b010;
  localparam logic [2:0] AOP_AND   = 3'b011;
  localparam logic [2:0] AOP_OR    = 3'b100;
  localparam logic [2:0] AOP_SLT   = 3'b101;
  localparam logic [2:0] AOP_LUI   = 3'b110;
  localparam logic [2:0] AOP_XOR   = 3'b111;

  localparam logic [5:0] F_SLL   = 6'd0;
  localparam logic [5:0] F_SRL   = 6'd2;
  localparam logic [5:0] F_SRA   = 6'd3;
  localparam logic [5:0] F_JR    = 6'd8;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MTHI  = 6'd17;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_MTLO  = 6'd19;
  localparam logic [5:0] F_MULT  = 6'd24;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIV   = 6'd26;
  localparam logic [5:0] F_DIVU  = 6'd27;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_ADDU  = 6'd33;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_SUBU  = 6'd35;
  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_XOR   = 6'd38;
  localparam logic [5:0] F_NOR   = 6'd39;
  localparam logic [5:0] F_SLT   = 6'd42;
  localparam logic [5:0] F_SLTU  = 6'd43;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_t;

  function automatic logic [1:0] md_op_of(input logic [5:0] f);
    logic [1:0] op;
    case (f)
      F_MULT:  op = MD_MULT;
      F_MULTU: op = MD_MULTU;
      F_DIV:   op = MD_DIV;
      F_DIVU:  op = MD_DIVU;
      default: op = MD_MULT;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_ctrl_seq_decode.sv
// Combinational ALU control decode: main-decoder opcode plus function field
// into ALU code, jr/illegal flags and mult/div / HI-LO access classification.
module alu_funct_decode
  import alu_ctrl_pkg::*;
#(
  parameter int FUNCT_W = 6
) (
  input  logic [2:0]         alu_op,
  input  logic [FUNCT_W-1:0] funct,
  output logic [3:0]         alu_ctl,
  output logic               jr,
  output logic               illegal,
  output logic               is_md,
  output logic               is_hilo
);

  // decode opcode and, for R-type, the function field
  always_comb begin
    alu_ctl = ALU_ADD;
    jr      = 1'b0;
    illegal = 1'b0;
    is_md   = 1'b0;
    is_hilo = 1'b0;
    case (alu_op)
      AOP_RTYPE: begin
        case (funct)
          F_ADD, F_ADDU: alu_ctl = ALU_ADD;
          F_SUB, F_SUBU: alu_ctl = ALU_SUB;
          F_AND:         alu_ctl = ALU_AND;
          F_OR:          alu_ctl = ALU_OR;
          F_XOR:         alu_ctl = ALU_XOR;
          F_NOR:         alu_ctl = ALU_NOR;
          F_SLT:         alu_ctl = ALU_SLT;
          F_SLTU:        alu_ctl = ALU_SLTU;
          F_SLL:         alu_ctl = ALU_SLL;
          F_SRL:         alu_ctl = ALU_SRL;
          F_SRA:         alu_ctl = ALU_SRA;
          F_JR: begin
            alu_ctl = ALU_NOP;
            jr      = 1'b1;
          end
          F_MFHI, F_MTHI, F_MFLO, F_MTLO: begin
            alu_ctl = ALU_NOP;
            is_hilo = 1'b1;
          end
          F_MULT, F_MULTU, F_DIV, F_DIVU: begin
            alu_ctl = ALU_NOP;
            is_md   = 1'b1;
          end
          default: begin
            alu_ctl = ALU_ADD;
            illegal = 1'b1;
          end
        endcase
      end
      AOP_ADD: alu_ctl = ALU_ADD;
      AOP_SUB: alu_ctl = ALU_SUB;
      AOP_AND: alu_ctl = ALU_AND;
      AOP_OR:  alu_ctl = ALU_OR;
      AOP_SLT: alu_ctl = ALU_SLT;
      AOP_LUI: alu_ctl = ALU_LUI;
      AOP_XOR: alu_ctl = ALU_XOR;
      default: alu_ctl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// ID/EX ALU control register plus mult/div sequencer with HI/LO interlock.
// HI/LO readers and new mult/div ops stall while the unit is busy.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int FUNCT_W  = 6,
  parameter int ALUCTL_W = 4,
  parameter int MD_LAT   = 32,
  parameter int CNT_W    = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic                flush,
  input  logic [2:0]          alu_op,
  input  logic [FUNCT_W-1:0]  funct,
  output logic                ex_valid,
  output logic [ALUCTL_W-1:0] alu_ctl,
  output logic                jr,
  output logic                illegal,
  output logic                stall,
  output logic                md_start,
  output logic [1:0]          md_op,
  output logic                md_busy,
  output logic                hilo_we
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LAT - 1);

  logic [3:0]       dec_ctl_s;
  logic             dec_jr_s;
  logic             dec_ill_s;
  logic             is_md_s;
  logic             is_hilo_s;
  logic             load_s;
  logic             start_s;
  md_state_t        state_r;
  md_state_t        state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;

  alu_funct_decode #(.FUNCT_W(FUNCT_W)) u_dec (
    .alu_op  (alu_op),
    .funct   (funct),
    .alu_ctl (dec_ctl_s),
    .jr      (dec_jr_s),
    .illegal (dec_ill_s),
    .is_md   (is_md_s),
    .is_hilo (is_hilo_s)
  );

  assign stall   = id_valid & ~flush & md_busy & (is_md_s | is_hilo_s);
  assign load_s  = id_valid & ~flush & ~stall;
  assign start_s = load_s & is_md_s;

  // mult/div sequencer next state; a new op may launch straight from DONE
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_nxt_s = ST_BUSY;
          cnt_nxt_s   = CNT_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_nxt_s = ST_DONE;
        end else begin
          cnt_nxt_s = cnt_r - CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (start_s) begin
          state_nxt_s = ST_BUSY;
          cnt_nxt_s   = CNT_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // pipeline register and registered sequencer outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      ex_valid <= 1'b0;
      alu_ctl  <= {ALUCTL_W{1'b0}};
      jr       <= 1'b0;
      illegal  <= 1'b0;
      md_start <= 1'b0;
      md_op    <= 2'b00;
      md_busy  <= 1'b0;
      hilo_we  <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      cnt_r    <= cnt_nxt_s;
      ex_valid <= load_s;
      alu_ctl  <= load_s ? ALUCTL_W'(dec_ctl_s) : ALUCTL_W'(ALU_NOP);
      jr       <= load_s & dec_jr_s;
      illegal  <= load_s & dec_ill_s;
      md_start <= start_s;
      md_busy  <= (state_nxt_s == ST_BUSY);
      hilo_we  <= (state_nxt_s == ST_DONE);
      if (start_s) begin
        md_op <= md_op_of(funct[5:0]);
      end
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench for alu_ctrl_seq with MD_LAT=4: decode table plus hand-written
// mult/div, interlock, back-to-back, reset-abort and flush sequences.
module tb_alu_ctrl_seq;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic       flush;
  logic [2:0] alu_op;
  logic [5:0] funct;
  logic       ex_valid;
  logic [3:0] alu_ctl;
  logic       jr;
  logic       illegal;
  logic       stall;
  logic       md_start;
  logic [1:0] md_op;
  logic       md_busy;
  logic       hilo_we;

  int n_chk  = 0;
  int n_fail = 0;

  alu_ctrl_seq #(.FUNCT_W(6), .ALUCTL_W(4), .MD_LAT(4), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .flush(flush),
    .alu_op(alu_op), .funct(funct), .ex_valid(ex_valid), .alu_ctl(alu_ctl),
    .jr(jr), .illegal(illegal), .stall(stall), .md_start(md_start),
    .md_op(md_op), .md_busy(md_busy), .hilo_we(hilo_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic       fl;
    logic [2:0] op;
    logic [5:0] fn;
    logic       ev;
    logic [3:0] ctl;
    logic       jr;
    logic       ill;
  } vec_t;

  vec_t vt[32];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic fl, input logic [2:0] op, input logic [5:0] fn);
    id_valid = v;
    flush    = fl;
    alu_op   = op;
    funct    = fn;
    #1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    id_valid = 1'b0; flush = 1'b0; alu_op = 3'd0; funct = 6'd0;
    // v, fl, op, fn, ev, ctl, jr, ill
    vt[0]  = '{1'b1, 1'b0, 3'd0, 6'd34, 1'b1, 4'b0001, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 3'd0, 6'd8,  1'b1, 4'b1111, 1'b1, 1'b0};
    vt[2]  = '{1'b1, 1'b0, 3'd0, 6'd63, 1'b1, 4'b0000, 1'b0, 1'b1};
    vt[3]  = '{1'b1, 1'b0, 3'd0, 6'd32, 1'b1, 4'b0000, 1'b0, 1'b0};
    vt[4]  = '{1'b1, 1'b0, 3'd0, 6'd33, 1'b1, 4'b0000, 1'b0, 1'b0};
    vt[5]  = '{1'b1, 1'b0, 3'd0, 6'd35, 1'b1, 4'b0001, 1'b0, 1'b0};
    vt[6]  = '{1'b1, 1'b0, 3'd0, 6'd36, 1'b1, 4'b0010, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 1'b0, 3'd0, 6'd37, 1'b1, 4'b0011, 1'b0, 1'b0};
    vt[8]  = '{1'b1, 1'b0, 3'd0, 6'd38, 1'b1, 4'b1001, 1'b0, 1'b0};
    vt[9]  = '{1'b1, 1'b0, 3'd0, 6'd39, 1'b1, 4'b1000, 1'b0, 1'b0};
    vt[10] = '{1'b1, 1'b0, 3'd0, 6'd42, 1'b1, 4'b0111, 1'b0, 1'b0};
    vt[11] = '{1'b1, 1'b0, 3'd0, 6'd43, 1'b1, 4'b1010, 1'b0, 1'b0};
    vt[12] = '{1'b1, 1'b0, 3'd0, 6'd0,  1'b1, 4'b0100, 1'b0, 1'b0};
    vt[13] = '{1'b1, 1'b0, 3'd0, 6'd2,  1'b1, 4'b0101, 1'b0, 1'b0};
    vt[14] = '{1'b1, 1'b0, 3'd0, 6'd3,  1'b1, 4'b0110, 1'b0, 1'b0};
    vt[15] = '{1'b1, 1'b0, 3'd0, 6'd16, 1'b1, 4'b1111, 1'b0, 1'b0};
    vt[16] = '{1'b1, 1'b0, 3'd0, 6'd17, 1'b1, 4'b1111, 1'b0, 1'b0};
    vt[17] = '{1'b1, 1'b0, 3'd0, 6'd18, 1'b1, 4'b1111, 1'b0, 1'b0};
    vt[18] = '{1'b1, 1'b0, 3'd0, 6'd19, 1'b1, 4'b1111, 1'b0, 1'b0};
    vt[19] = '{1'b1, 1'b0, 3'd0, 6'd1,  1'b1, 4'b0000, 1'b0, 1'b1};
    vt[20] = '{1'b1, 1'b0, 3'd1, 6'd63, 1'b1, 4'b0000, 1'b0, 1'b0};
    vt[21] = '{1'b1, 1'b0, 3'd2, 6'd8,  1'b1, 4'b0001, 1'b0, 1'b0};
    vt[22] = '{1'b1, 1'b0, 3'd3, 6'd24, 1'b1, 4'b0010, 1'b0, 1'b0};
    vt[23] = '{1'b1, 1'b0, 3'd4, 6'd0,  1'b1, 4'b0011, 1'b0, 1'b0};
    vt[24] = '{1'b1, 1'b0, 3'd5, 6'd0,  1'b1, 4'b0111, 1'b0, 1'b0};
    vt[25] = '{1'b1, 1'b0, 3'd6, 6'd0,  1'b1, 4'b1011, 1'b0, 1'b0};
    vt[26] = '{1'b1, 1'b0, 3'd7, 6'd0,  1'b1, 4'b1001, 1'b0, 1'b0};
    vt[27] = '{1'b0, 1'b0, 3'd0, 6'd34, 1'b0, 4'b1111, 1'b0, 1'b0};
    vt[28] = '{1'b1, 1'b1, 3'd0, 6'd8,  1'b0, 4'b1111, 1'b0, 1'b0};
    vt[29] = '{1'b1, 1'b1, 3'd0, 6'd24, 1'b0, 4'b1111, 1'b0, 1'b0};
    vt[30] = '{1'b1, 1'b1, 3'd0, 6'd63, 1'b0, 4'b1111, 1'b0, 1'b0};
    vt[31] = '{1'b0, 1'b0, 3'd0, 6'd27, 1'b0, 4'b1111, 1'b0, 1'b0};

    cyc();
    cyc();
    chk("reset_outs", {ex_valid, alu_ctl, jr, illegal, stall, md_start, md_op, md_busy, hilo_we},
        13'd0);
    rst = 1'b0;

    // single-cycle decode table
    for (int i = 0; i < 32; i++) begin
      drive(vt[i].v, vt[i].fl, vt[i].op, vt[i].fn);
      chk($sformatf("vec%0d_stall", i), {31'd0, stall}, 32'd0);
      cyc();
      chk($sformatf("vec%0d_ex", i), {ex_valid, alu_ctl, jr, illegal},
          {vt[i].ev, vt[i].ctl, vt[i].jr, vt[i].ill});
      chk($sformatf("vec%0d_md", i), {md_start, md_busy, hilo_we}, 3'b000);
    end
    drive(1'b0, 1'b0, 3'd0, 6'd0);
    cyc();

    // mult with interlocked mflo and a non-blocked add while busy
    drive(1'b1, 1'b0, 3'd0, 6'd24);
    cyc();
    chk("mult_e1_md", {md_start, md_op, md_busy, hilo_we}, 5'b1_00_1_0);
    chk("mult_e1_ex", {ex_valid, alu_ctl, jr, illegal}, 7'b1_1111_0_0);
    drive(1'b1, 1'b0, 3'd0, 6'd18);
    chk("mflo_e1_stall", {31'd0, stall}, 32'd1);
    cyc();
    chk("mflo_e2_ex", {ex_valid, alu_ctl, jr, illegal}, 7'b0_1111_0_0);
    chk("mult_e2_md", {md_start, md_busy, hilo_we}, 3'b010);
    drive(1'b1, 1'b0, 3'd0, 6'd32);
    chk("add_busy_stall", {31'd0, stall}, 32'd0);
    cyc();
    chk("add_busy_ex", {ex_valid, alu_ctl, jr, illegal}, 7'b1_0000_0_0);
    chk("mult_e3_md", {md_start, md_busy, hilo_we}, 3'b010);
    drive(1'b1, 1'b0, 3'd0, 6'd18);
    chk("mflo_e3_stall", {31'd0, stall}, 32'd1);
    cyc();
    chk("mflo_e4_ex", {ex_valid, alu_ctl, jr, illegal}, 7'b0_1111_0_0);
    chk("mult_e4_md", {md_start, md_busy, hilo_we}, 3'b010);
    chk("mflo_e4_stall", {31'd0, stall}, 32'd1);
    cyc();
    chk("mult_done_md", {md_start, md_busy, hilo_we}, 3'b001);
    chk("mflo_e5_ex", {ex_valid, alu_ctl, jr, illegal}, 7'b0_1111_0_0);
    chk("mflo_e5_stall", {31'd0, stall}, 32'd0);
    cyc();
    chk("mflo_e6_ex", {ex_valid, alu_ctl, jr, illegal}, 7'b1_1111_0_0);
    chk("mult_e6_md", {md_start, md_busy, hilo_we}, 3'b000);
    drive(1'b0, 1'b0, 3'd0, 6'd0);
    cyc();

    // mult, then divu captured in the DONE cycle, then reset mid-busy
    drive(1'b1, 1'b0, 3'd0, 6'd25);
    cyc();
    drive(1'b0, 1'b0, 3'd0, 6'd0);
    chk("multu_start", {md_start, md_op, md_busy}, 4'b1_01_1);
    cyc();
    cyc();
    cyc();
    chk("multu_last_busy", {md_start, md_busy, hilo_we}, 3'b010);
    cyc();
    chk("multu_done", {md_start, md_busy, hilo_we}, 3'b001);
    drive(1'b1, 1'b0, 3'd0, 6'd27);
    chk("divu_done_stall", {31'd0, stall}, 32'd0);
    cyc();
    chk("divu_start", {md_start, md_op, md_busy, hilo_we}, 5'b1_11_1_0);
    drive(1'b0, 1'b0, 3'd0, 6'd0);
    cyc();
    cyc();
    chk("divu_mid_busy", {md_start, md_busy, hilo_we}, 3'b010);
    rst = 1'b1;
    cyc();
    chk("rst_mid_busy", {ex_valid, alu_ctl, jr, illegal, stall, md_start, md_op, md_busy, hilo_we},
        13'd0);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk($sformatf("post_rst%0d", k), {md_start, md_busy, hilo_we}, 3'b000);
    end

    // flushed mult must not launch
    drive(1'b1, 1'b1, 3'd0, 6'd24);
    cyc();
    drive(1'b0, 1'b0, 3'd0, 6'd0);
    chk("flush_mult", {ex_valid, md_start, md_busy}, 3'b000);
    cyc();
    chk("flush_mult_after", {md_start, md_busy, hilo_we}, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
